mb_seq: RTL and testbench

MB_SEQ -- requirements
Module: mb_seq

---
 rtl/alu_pkg.sv | 34 +++
 rtl/mb_seq.sv | 150 +++++++++++++++
 tb/tb_mb_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : alu_pkg
// Desc     : Opcode encoding and data widths shared with the external 8-bit ALU
// Revision : 1.0
// ============================================================================
package alu_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_XOR  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_LSL  = 4'd3,
    ALU_LSR  = 4'd4,
    ALU_ADD  = 4'd5,
    ALU_SUB  = 4'd6,
    ALU_PASS = 4'd7
  } alu_op_e;

  // Opcodes whose carry/shift bit ripples from the first byte into the second.
  function automatic logic is_carry_op(input logic [3:0] op);
    return (op == ALU_LSL) || (op == ALU_LSR) || (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

  // Upper half of the opcode space has no ALU work and completes immediately.
  function automatic logic is_direct_op(input logic [3:0] op);
    return op[3];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mb_seq.sv
`default_nettype none
// ============================================================================
// Module   : mb_seq
// Desc     : Sequences a 16-bit request through an external 8-bit ALU, two bytes
// Revision : 1.0
// ============================================================================
module mb_seq
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [WORD_W-1:0] req_a,
  input  logic [WORD_W-1:0] req_b,
  input  logic              req_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_result,
  output logic              rsp_cout,
  output logic [3:0]        alu_cmd,
  output logic [BYTE_W-1:0] alu_in_a,
  output logic [BYTE_W-1:0] alu_in_b,
  output logic              alu_cin,
  input  logic [BYTE_W-1:0] alu_rslt,
  input  logic              alu_cout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BYTE0 = 2'd1,
    ST_BYTE1 = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [3:0]        r_op;
  logic [WORD_W-1:0] r_a;
  logic [WORD_W-1:0] r_b;
  logic              r_cin;
  logic              r_carry;
  logic [WORD_W-1:0] r_result;
  logic              r_cout;

  logic              w_accept;
  logic              w_chain;
  logic              w_hi_first;
  logic              w_hi_byte;
  logic [BYTE_W-1:0] w_byte_a;
  logic [BYTE_W-1:0] w_byte_b;

  assign w_accept   = req_valid && req_ready;
  assign w_chain    = is_carry_op(r_op);
  // Right shift must see the high byte first so its shift-out feeds the low byte.
  assign w_hi_first = (r_op == ALU_LSR);
  assign w_hi_byte  = (r_state == ST_BYTE0) ? w_hi_first : !w_hi_first;
  assign w_byte_a   = w_hi_byte ? r_a[WORD_W-1:BYTE_W] : r_a[BYTE_W-1:0];
  assign w_byte_b   = w_hi_byte ? r_b[WORD_W-1:BYTE_W] : r_b[BYTE_W-1:0];

  assign rsp_result = r_result;
  assign rsp_cout   = r_cout;

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    alu_cmd     = ALU_PASS;
    alu_in_a    = '0;
    alu_in_b    = '0;
    alu_cin     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = is_direct_op(req_op) ? ST_DONE : ST_BYTE0;
        end
      end
      ST_BYTE0: begin
        alu_cmd     = r_op;
        alu_in_a    = w_byte_a;
        alu_in_b    = w_byte_b;
        alu_cin     = w_chain && r_cin;
        w_state_nxt = ST_BYTE1;
      end
      ST_BYTE1: begin
        alu_cmd     = r_op;
        alu_in_a    = w_byte_a;
        alu_in_b    = w_byte_b;
        alu_cin     = w_chain && r_carry;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cin    <= 1'b0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op     <= req_op;
            r_a      <= req_a;
            r_b      <= req_b;
            r_cin    <= req_cin;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
          end
        end
        ST_BYTE0: begin
          if (w_hi_byte) begin
            r_result[WORD_W-1:BYTE_W] <= alu_rslt;
          end else begin
            r_result[BYTE_W-1:0] <= alu_rslt;
          end
          r_carry <= w_chain && alu_cout;
        end
        ST_BYTE1: begin
          if (w_hi_byte) begin
            r_result[WORD_W-1:BYTE_W] <= alu_rslt;
          end else begin
            r_result[BYTE_W-1:0] <= alu_rslt;
          end
          r_cout <= w_chain && alu_cout;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mb_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mb_seq
// Desc     : Self-checking bench for mb_seq with a behavioural 8-bit ALU attached
// Revision : 1.0
// ============================================================================
module tb_mb_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [15:0] req_a = 16'd0;
  logic [15:0] req_b = 16'd0;
  logic        req_cin = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        rsp_cout;
  logic [3:0]  alu_cmd;
  logic [7:0]  alu_in_a;
  logic [7:0]  alu_in_b;
  logic        alu_cin;
  logic [7:0]  alu_rslt;
  logic        alu_cout;
  logic        noise_cout = 1'b0;

  int n_asserts = 0;
  int n_fails   = 0;

  always #5 clk = ~clk;

  mb_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout),
    .alu_cmd    (alu_cmd),
    .alu_in_a   (alu_in_a),
    .alu_in_b   (alu_in_b),
    .alu_cin    (alu_cin),
    .alu_rslt   (alu_rslt),
    .alu_cout   (alu_cout)
  );

  // External ALU; logic ops drive an arbitrary carry-out the sequencer must ignore.
  always_comb begin
    alu_rslt = alu_in_a;
    alu_cout = noise_cout;
    case (alu_cmd)
      4'd0: alu_rslt = alu_in_a & alu_in_b;
      4'd1: alu_rslt = alu_in_a ^ alu_in_b;
      4'd2: alu_rslt = alu_in_a | alu_in_b;
      4'd3: {alu_cout, alu_rslt} = {alu_in_a, alu_cin};
      4'd4: {alu_rslt, alu_cout} = {alu_cin, alu_in_a};
      4'd5: {alu_cout, alu_rslt} = {1'b0, alu_in_a} + {1'b0, alu_in_b} + 9'(alu_cin);
      4'd6: {alu_cout, alu_rslt} = {1'b0, alu_in_a} + {1'b0, ~alu_in_b} + 9'(alu_cin);
      default: ;
    endcase
  end

  // Whole-word reference: returns {cout, result}.
  function automatic logic [16:0] ref_word(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin);
    case (op)
      4'd0: return {1'b0, a & b};
      4'd1: return {1'b0, a ^ b};
      4'd2: return {1'b0, a | b};
      4'd3: return {a, cin};
      4'd4: return {a[0], cin, a[15:1]};
      4'd5: return {1'b0, a} + {1'b0, b} + 17'(cin);
      4'd6: return {1'b0, a} + {1'b0, ~b} + 17'(cin);
      4'd7: return {1'b0, a};
      default: return 17'd0;
    endcase
  endfunction

  // Carry handed from the first processed byte to the second.
  function automatic logic ref_mid_carry(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
    logic [8:0] s;
    case (op)
      4'd3: return a[7];
      4'd4: return a[8];
      4'd5: begin s = {1'b0, a[7:0]} + {1'b0, b[7:0]} + 9'(cin); return s[8]; end
      4'd6: begin s = {1'b0, a[7:0]} + {1'b0, ~b[7:0]} + 9'(cin); return s[8]; end
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends just after a falling edge with the sequencer idle.
  task automatic run_txn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input int hold, input logic ext_cout);
    logic [16:0] exp;
    logic        chain;
    logic        hi_first;
    exp      = ref_word(op, a, b, cin);
    chain    = (op >= 4'd3) && (op <= 4'd6);
    hi_first = (op == 4'd4);
    noise_cout = ext_cout;
    check("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cin = cin;
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 4'($urandom); req_a = 16'($urandom); req_b = 16'($urandom); req_cin = 1'($urandom);
    if (!op[3]) begin
      check("b0_rsp_valid", rsp_valid, 0);
      check("b0_req_ready", req_ready, 0);
      check("b0_alu_cmd", alu_cmd, op);
      check("b0_alu_in_a", alu_in_a, hi_first ? a[15:8] : a[7:0]);
      check("b0_alu_in_b", alu_in_b, hi_first ? b[15:8] : b[7:0]);
      check("b0_alu_cin", alu_cin, chain ? cin : 1'b0);
      @(negedge clk);
      check("b1_rsp_valid", rsp_valid, 0);
      check("b1_alu_cmd", alu_cmd, op);
      check("b1_alu_in_a", alu_in_a, hi_first ? a[7:0] : a[15:8]);
      check("b1_alu_in_b", alu_in_b, hi_first ? b[7:0] : b[15:8]);
      check("b1_alu_cin", alu_cin, ref_mid_carry(op, a, b, cin));
    end
    @(negedge clk);
    check("done_rsp_valid", rsp_valid, 1);
    check("done_result", rsp_result, exp[15:0]);
    check("done_cout", rsp_cout, exp[16]);
    check("done_alu_cmd", alu_cmd, 4'd7);
    check("done_alu_in_a", alu_in_a, 0);
    check("done_alu_cin", alu_cin, 0);
    check("done_req_ready", req_ready, 0);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_result", rsp_result, exp[15:0]);
      check("hold_cout", rsp_cout, exp[16]);
      check("hold_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_req_ready", req_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_result", rsp_result, 0);
    check("rst_cout", rsp_cout, 0);
    check("rst_alu_cmd", alu_cmd, 4'd7);
    check("rst_alu_in_a", alu_in_a, 0);
    check("rst_alu_in_b", alu_in_b, 0);
    check("rst_alu_cin", alu_cin, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_req_ready", req_ready, 1);

    run_txn(4'd5, 16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
    run_txn(4'd3, 16'h8001, 16'h0000, 1'b1, 0, 1'b0);
    run_txn(4'd4, 16'h0180, 16'h0000, 1'b0, 0, 1'b0);
    run_txn(4'd1, 16'hF0F0, 16'hFFFF, 1'b0, 0, 1'b1);
    run_txn(4'd10, 16'h1234, 16'h5678, 1'b1, 0, 1'b1);
    run_txn(4'd5, 16'h1234, 16'h4321, 1'b1, 5, 1'b0);
    run_txn(4'd6, 16'h0100, 16'h0001, 1'b1, 1, 1'b0);
    run_txn(4'd6, 16'h0000, 16'h0001, 1'b1, 0, 1'b0);

    // Abort an ADD while its high byte is in flight.
    req_valid = 1'b1; req_op = 4'd5; req_a = 16'hFFFF; req_b = 16'h0001; req_cin = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_result", rsp_result, 0);
    check("abort_cout", rsp_cout, 0);
    check("abort_alu_cmd", alu_cmd, 4'd7);
    check("abort_alu_in_a", alu_in_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_rsp", rsp_valid, 0);
      check("abort_req_ready", req_ready, 1);
    end
    run_txn(4'd5, 16'h7FFF, 16'h8001, 1'b0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      run_txn(4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
